// File: rtl/rv_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : rv_dmem_slave
// Brief    : LSU data-memory slave: two-phase handshake, byte-lane word SRAM,
//            programmable wait states. Optional fault checking under the
//            DMEM_ERR_CHK_EN macro (adds the Mem_err port).
// Revision : 1.0 - initial release
// ============================================================================
module rv_dmem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Address_vld,
    input  logic [31:0] MemAddress_i,
    input  logic        MemOp,
    input  logic [1:0]  MemOpSize,
    output logic        Address_rsp,
    input  logic        WData_vld,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        Data_rsp
`ifdef DMEM_ERR_CHK_EN
    ,
    output logic        Mem_err
`endif
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ACK  = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [3:0]         r_wait_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [1:0]         r_lo;
    logic               r_write;
    logic [1:0]         r_size;
    logic [31:0]        r_rdata;
    logic [3:0]         w_be;
    logic               w_accept;
    logic               w_commit;
    logic               w_fault;

    logic [31:0] r_mem [DEPTH_WORDS];

    assign w_accept = (r_state == c_ST_IDLE) && Address_vld;
    assign w_commit = (r_state == c_ST_DATA) && WData_vld;

    // BASE_ADDR is aligned to the array size, so (addr - BASE) >> 2 modulo
    // depth reduces to the plain address slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_lo    <= 2'b00;
            r_write <= 1'b0;
            r_size  <= 2'b00;
        end else if (w_accept) begin
            r_idx   <= MemAddress_i[c_IDX_W+1:2];
            r_lo    <= MemAddress_i[1:0];
            r_write <= MemOp;
            r_size  <= MemOpSize;
        end
    end

`ifdef DMEM_ERR_CHK_EN
    logic r_fault;
    logic w_misalign;
    logic w_out_of_range;

    assign w_misalign     = ((MemOpSize == 2'd1) && MemAddress_i[0]) ||
                            (MemOpSize[1] && (MemAddress_i[1:0] != 2'b00));
    assign w_out_of_range = MemAddress_i[31:c_IDX_W+2] != BASE_ADDR[31:c_IDX_W+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_misalign || w_out_of_range;
        end
    end

    assign w_fault = r_fault;
    assign Mem_err = (r_state == c_ST_RESP) && r_fault;
`else
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, MemAddress_i[31:c_IDX_W+2]};
    assign w_fault       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == c_ST_ACK) begin
            r_wait_cnt <= c_WAIT;
        end else if (r_state == c_ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (Address_vld) w_state_nxt = c_ST_ACK;
            c_ST_ACK:  w_state_nxt = (c_WAIT == 4'd0) ? c_ST_DATA : c_ST_WAIT;
            c_ST_WAIT: if (r_wait_cnt == 4'd1) w_state_nxt = c_ST_DATA;
            c_ST_DATA: if (WData_vld) w_state_nxt = c_ST_RESP;
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lo;
            2'd1:    w_be = r_lo[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // The array has no reset; a synchronous reset landing on the commit
    // cycle must still suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_write && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= WriteData_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (w_commit) begin
            r_rdata <= (r_write || w_fault) ? 32'h0 : r_mem[r_idx];
        end
    end

    assign Address_rsp = (r_state == c_ST_ACK);
    assign Data_rsp    = (r_state == c_ST_RESP);
    assign ReadData_o  = Data_rsp ? r_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rv_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_dmem_slave
// Brief    : Bench for rv_dmem_slave; two instances (no wait states, and
//            WAIT_CYCLES=3 with a non-zero base) checked against a word-array
//            model and a handshake timing schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_dmem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        op;
    logic [1:0]  size;
    logic        avld [2];
    logic        wvld [2];
    logic        arsp [2];
    logic        drsp [2];
    logic [31:0] rdat [2];
    logic        merr [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    int          ea  [2] = '{-1, -1};
    int          ed  [2] = '{-1, -1};
    logic [31:0] erd [2] = '{32'h0, 32'h0};
    logic        eer [2] = '{1'b0, 1'b0};

    logic [31:0] mm [2][1024];

    int          last_ta;
    int          last_td;
    int          last_na;
    logic [31:0] last_got;
    logic        last_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_dmem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .Address_vld(avld[0]), .MemAddress_i(addr), .MemOp(op),
        .MemOpSize(size), .Address_rsp(arsp[0]), .WData_vld(wvld[0]), .WriteData_i(wdata),
        .ReadData_o(rdat[0]), .Data_rsp(drsp[0])
`ifdef DMEM_ERR_CHK_EN
        , .Mem_err(merr[0])
`endif
    );

    rv_dmem_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .Address_vld(avld[1]), .MemAddress_i(addr), .MemOp(op),
        .MemOpSize(size), .Address_rsp(arsp[1]), .WData_vld(wvld[1]), .WriteData_i(wdata),
        .ReadData_o(rdat[1]), .Data_rsp(drsp[1])
`ifdef DMEM_ERR_CHK_EN
        , .Mem_err(merr[1])
`endif
    );

`ifndef DMEM_ERR_CHK_EN
    initial begin
        merr[0] = 1'b0;
        merr[1] = 1'b0;
    end
`endif

    function automatic int dep(input int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    function automatic logic [31:0] base(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
    endfunction

    function automatic int waits(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle, each DUT's outputs must match the handshake schedule
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d_Address_rsp", d), {31'b0, arsp[d]}, {31'b0, cyc == ea[d]});
                chk($sformatf("dut%0d_Data_rsp", d), {31'b0, drsp[d]}, {31'b0, cyc == ed[d]});
                chk($sformatf("dut%0d_ReadData_o", d), rdat[d], (cyc == ed[d]) ? erd[d] : 32'h0);
`ifdef DMEM_ERR_CHK_EN
                chk($sformatf("dut%0d_Mem_err", d), {31'b0, merr[d]},
                    {31'b0, (cyc == ed[d]) && eer[d]});
`endif
            end
        end
    end

    // One LSU transaction. dly: cycles after ACK+1 before WData_vld rises.
    // hold: Address_vld stays high through cycle k+hold. rst_at>=0 aborts
    // with a reset pulse in cycle k+rst_at.
    task automatic txn(input int d, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int dly, input int hold, input int rst_at);
        int     k;
        int     e_d;
        int     c;
        int     idx;
        bit     fault;
        bit     done;
        longint off;
        logic [3:0] be;
        @(posedge clk);
        #1;
        k   = cyc;
        off = longint'(a) - longint'(base(d));
        idx = int'(((a - base(d)) >> 2) % 32'(dep(d)));
        fault = 1'b0;
`ifdef DMEM_ERR_CHK_EN
        fault = (off < 0) || (off >= longint'(dep(d) * 4)) ||
                ((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0));
`endif
        if (sz == 2'd0)      be = 4'(1 << (a % 4));
        else if (sz == 2'd1) be = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        else                 be = 4'b1111;
        e_d = ((waits(d) > dly) ? (k + 2 + waits(d)) : (k + 2 + dly)) + 1;
        ea[d]  = k + 1;
        ed[d]  = (rst_at >= 0) ? -1 : e_d;
        erd[d] = (fault || wr) ? 32'h0 : mm[d][idx];
        eer[d] = fault;
        last_ta = -1; last_td = -1; last_na = 0; last_got = 32'h0; last_err = 1'b0;
        addr = a; op = wr; size = sz; wdata = wd; avld[d] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (arsp[d]) begin
                last_na++;
                if (last_ta < 0) last_ta = cyc - k;
            end
            if (drsp[d]) begin
                last_td  = cyc - k;
                last_got = rdat[d];
                last_err = merr[d];
            end
            @(posedge clk);
            #1;
            c = cyc;
            avld[d] = (c <= k + hold);
            if (rst_at >= 0) begin
                rst     = (c == k + rst_at);
                wvld[d] = (c >= k + 2 + dly) && (c <= k + rst_at);
                done    = (c == k + rst_at + 1);
            end else begin
                wvld[d] = (c >= k + 2 + dly) && (c <= e_d);
                done    = (c == e_d + 1);
            end
        end
        avld[d] = 1'b0; wvld[d] = 1'b0; rst = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL dut%0d_timeout: transaction at %h did not complete, expected rsp by cycle %0d",
                     d, a, e_d);
        end
        if (rst_at < 0 && wr && !fault) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mm[d][idx][8*l +: 8] = wd[8*l +: 8];
        end
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; op = 1'b0; size = 2'd0;
        avld[0] = 1'b0; avld[1] = 1'b0; wvld[0] = 1'b0; wvld[1] = 1'b0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Word store then load
        txn(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 0, 1, -1);
        chk("t1_wr_ack_lat", 32'(last_ta), 32'd1);
        chk("t1_wr_rsp_lat", 32'(last_td), 32'd3);
        txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 0, 1, -1);
        chk("t1_rd_data", last_got, 32'hDEAD_BEEF);
        chk("t1_rd_ack_lat", 32'(last_ta), 32'd1);

        // Byte lanes
        txn(0, 1'b1, 2'd2, 32'h0, 32'h0, 0, 1, -1);
        txn(0, 1'b1, 2'd0, 32'h2, 32'hA5A5_A5A5, 0, 1, -1);
        txn(0, 1'b1, 2'd1, 32'h0, 32'h1234_1234, 1, 1, -1);
        txn(0, 1'b0, 2'd2, 32'h0, 32'h0, 0, 1, -1);
        chk("t2_lanes_data", last_got, 32'h00A5_1234);
        chk("t2_model_word0", mm[0][0], 32'h00A5_1234);
        txn(0, 1'b1, 2'd1, 32'h12, 32'h7788_7788, 0, 1, -1);
        txn(0, 1'b0, 2'd1, 32'h10, 32'h0, 2, 1, -1);
        chk("t2_hi_half_data", last_got, 32'h7788_BEEF);

        // Wait states
        txn(1, 1'b1, 2'd2, 32'h1004, 32'h0BAD_CAFE, 0, 1, -1);
        txn(1, 1'b0, 2'd2, 32'h1004, 32'h0, 0, 1, -1);
        chk("t3_rsp_after_ack", 32'(last_td - last_ta), 32'd5);
        chk("t3_rd_data", last_got, 32'h0BAD_CAFE);

        // Reset mid-operation
        txn(1, 1'b1, 2'd2, 32'h1008, 32'h2222_2222, 0, 1, -1);
        txn(1, 1'b1, 2'd2, 32'h1008, 32'h1111_1111, 0, 1, 3);
        txn(1, 1'b0, 2'd2, 32'h1008, 32'h0, 0, 1, -1);
        chk("t4_word_kept", last_got, 32'h2222_2222);
        chk("t4_idle_after_rst", 32'(last_ta), 32'd1);

        // Held request across ACK
        txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 2, 2, -1);
        chk("t5_single_ack", 32'(last_na), 32'd1);
        chk("t5_rd_data", last_got, 32'h7788_BEEF);

        // Faults / wrap
        txn(0, 1'b1, 2'd2, 32'h4, 32'h5555_5555, 0, 1, -1);
        txn(0, 1'b1, 2'd2, 32'h6, 32'hCAFE_F00D, 0, 1, -1);
`ifdef DMEM_ERR_CHK_EN
        chk("t6_misalign_err", {31'b0, last_err}, 32'd1);
        txn(0, 1'b0, 2'd2, 32'h4, 32'h0, 0, 1, -1);
        chk("t6_word1_unchanged", last_got, 32'h5555_5555);
        txn(0, 1'b0, 2'd2, 32'h1000, 32'h0, 0, 1, -1);
        chk("t6_oor_err", {31'b0, last_err}, 32'd1);
        chk("t6_oor_rdata", last_got, 32'h0);
        txn(1, 1'b0, 2'd2, 32'h0FFC, 32'h0, 0, 1, -1);
        chk("t6_below_base_err", {31'b0, last_err}, 32'd1);
`else
        txn(0, 1'b0, 2'd2, 32'h4, 32'h0, 0, 1, -1);
        chk("t6_lands_word1", last_got, 32'hCAFE_F00D);
        txn(0, 1'b0, 2'd2, 32'h1000, 32'h0, 0, 1, -1);
        chk("t6_wrap_word0", last_got, 32'h00A5_1234);
        txn(1, 1'b0, 2'd2, 32'h1044, 32'h0, 0, 1, -1);
        chk("t6_wrap_dut1", last_got, 32'h0BAD_CAFE);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
